// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter that lets two word-oriented requesters share a byte-wide
// single-port data memory, splitting each 32-bit access into four big-endian byte cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_cnt;
    logic              r_owner;
    logic              r_lastOwner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rbuf;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;

    logic              w_accept;
    logic              w_winner;
    logic              w_xfer;
    logic [1:0]        w_byteSel;
    logic [4:0]        w_bitOfs;

    assign w_accept  = (r_state != S_XFER) && (m0_req || m1_req);
    // On a tie the port that did not own the previous transfer wins.
    assign w_winner  = (m0_req && m1_req) ? ~r_lastOwner : m1_req;
    assign w_xfer    = (r_state == S_XFER);
    assign w_byteSel = 2'd3 - r_cnt;
    assign w_bitOfs  = {w_byteSel, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_XFER;
            S_XFER:  if (r_cnt == 2'd3) w_nextState = S_DONE;
            S_DONE:  w_nextState = w_accept ? S_XFER : S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 2'd0;
            r_owner     <= 1'b0;
            r_lastOwner <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_rbuf      <= 32'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_accept) begin
                r_owner     <= w_winner;
                r_lastOwner <= w_winner;
                r_we        <= w_winner ? m1_we    : m0_we;
                r_addr      <= w_winner ? m1_addr  : m0_addr;
                r_wdata     <= w_winner ? m1_wdata : m0_wdata;
                r_cnt       <= 2'd0;
                r_gnt0      <= ~w_winner;
                r_gnt1      <= w_winner;
            end
            if (w_xfer) begin
                r_cnt <= r_cnt + 2'd1;
                if (!r_we) begin
                    r_rbuf[w_bitOfs +: 8] <= mem_rdata;
                end
                // The last byte bypasses r_rbuf so rdata is complete in the done cycle.
                if (r_cnt == 2'd3) begin
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                    if (!r_we && !r_owner) r_rdata0 <= {r_rbuf[31:8], mem_rdata};
                    if (!r_we &&  r_owner) r_rdata1 <= {r_rbuf[31:8], mem_rdata};
                end
            end
        end
    end

    assign mem_we    = w_xfer && r_we;
    assign mem_addr  = w_xfer ? (r_addr + ADDR_W'(r_cnt)) : '0;
    assign mem_wdata = (w_xfer && r_we) ? r_wdata[w_bitOfs +: 8] : 8'd0;

    assign m0_gnt   = r_gnt0;
    assign m1_gnt   = r_gnt1;
    assign m0_done  = r_done0;
    assign m1_done  = r_done1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule
